// File: rtl/i2c_master_pkg.sv
// Shared state encoding and prescaler floor for the I2C master controller.
package i2c_master_pkg;

  localparam int MIN_PRESCALER = 2;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_START        = 4'd1,
    ST_WRITE_ADDR   = 4'd2,
    ST_READ_ACK     = 4'd3,
    ST_WRITE_DATA   = 4'd4,
    ST_READ_DATA    = 4'd5,
    ST_WRITE_ACK    = 4'd6,
    ST_REPEAT_START = 4'd7,
    ST_STOP         = 4'd8
  } state_t;

endpackage

// File: rtl/i2c_master_fsm_block_scl_gen.sv
// SCL generator: edge counter over one 2P-clock SCL period plus rise/wrap strobes.
module i2c_scl_gen_block (
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       force_high,
  input  logic [7:0] prescaler,
  output logic       scl,
  output logic       wrap,
  output logic       rise,
  output logic [7:0] edge_count
);

  logic [8:0] e;
  logic [8:0] two_p;

  assign two_p      = {prescaler, 1'b0};
  assign wrap       = !hold && (e == two_p - 9'd1);
  assign rise       = !hold && (e == {1'b0, prescaler});
  assign scl        = force_high || (e >= {1'b0, prescaler});
  assign edge_count = e[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e <= '0;
    end else if (hold || wrap) begin
      e <= '0;
    end else begin
      e <= e + 9'd1;
    end
  end

endmodule

// File: rtl/i2c_master_fsm_block.sv
// I2C master transaction controller: phase sequencing, SCL timing and handshake pulses.
module i2c_master_fsm_block
  import i2c_master_pkg::*;
#(
  parameter int MIN_PRESCALER = i2c_master_pkg::MIN_PRESCALER
) (
  input  logic       i2c_core_clock_i,
  input  logic       reset_bit_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] addr_rw_i,
  input  logic [7:0] byte_count_i,
  input  logic [7:0] prescaler_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       start_cnt_o,
  output logic       write_addr_cnt_o,
  output logic       write_data_cnt_o,
  output logic       read_data_cnt_o,
  output logic       write_ack_cnt_o,
  output logic       read_ack_cnt_o,
  output logic       stop_cnt_o,
  output logic       repeat_start_cnt_o,
  output logic [7:0] counter_detect_edge_o,
  output logic [7:0] counter_state_done_time_repeat_start_o,
  output logic       ack_bit_o,
  output logic       tx_req_o,
  output logic       rx_valid_o,
  output logic       done_o,
  output logic       nack_err_o
);

  state_t     state, next_state;
  logic [7:0] addr_rw_q, bytes_left, presc, p_eff;
  logic [2:0] bit_cnt;
  logic       ack_q;
  logic [8:0] rs_cnt;
  logic       hold, force_high, wrap, rise;
  logic       byte_state, eot_point, accept;
  logic       unused_addr_bits;

  // The address itself is consumed by the data path; only R/W steers sequencing.
  assign unused_addr_bits = ^addr_rw_q[7:1];

  assign p_eff = (prescaler_i < 8'(MIN_PRESCALER)) ? 8'(MIN_PRESCALER) : prescaler_i;

  i2c_scl_gen_block u_scl_gen (
    .clk        (i2c_core_clock_i),
    .rst        (reset_bit_i),
    .hold       (hold),
    .force_high (force_high),
    .prescaler  (presc),
    .scl        (scl_o),
    .wrap       (wrap),
    .rise       (rise),
    .edge_count (counter_detect_edge_o)
  );

  assign counter_state_done_time_repeat_start_o = rs_cnt[7:0];

  always_comb begin
    next_state         = state;
    hold               = 1'b0;
    force_high         = 1'b0;
    start_cnt_o        = 1'b0;
    write_addr_cnt_o   = 1'b0;
    write_data_cnt_o   = 1'b0;
    read_data_cnt_o    = 1'b0;
    write_ack_cnt_o    = 1'b0;
    read_ack_cnt_o     = 1'b0;
    stop_cnt_o         = 1'b0;
    repeat_start_cnt_o = 1'b0;
    ack_bit_o          = 1'b0;
    byte_state = (state == ST_WRITE_ADDR) || (state == ST_WRITE_DATA) || (state == ST_READ_DATA);
    // Last-ACK wrap with nothing left: a waiting command turns into a repeated start.
    eot_point = wrap && (bytes_left == 8'd0) &&
                (((state == ST_READ_ACK) && !ack_q) || (state == ST_WRITE_ACK));
    cmd_ready_o = (state == ST_IDLE) || eot_point;
    accept      = cmd_valid_i && cmd_ready_o;

    unique case (state)
      ST_IDLE: begin
        hold       = 1'b1;
        force_high = 1'b1;
        if (accept) next_state = ST_START;
      end
      ST_START: begin
        start_cnt_o = 1'b1;
        force_high  = 1'b1;
        if (wrap) next_state = ST_WRITE_ADDR;
      end
      ST_WRITE_ADDR: begin
        write_addr_cnt_o = 1'b1;
        if (wrap && bit_cnt == 3'd7) next_state = ST_READ_ACK;
      end
      ST_READ_ACK: begin
        read_ack_cnt_o = 1'b1;
        if (wrap) begin
          if (ack_q)                   next_state = ST_STOP;
          else if (bytes_left != 8'd0) next_state = addr_rw_q[0] ? ST_READ_DATA : ST_WRITE_DATA;
          else                         next_state = accept ? ST_REPEAT_START : ST_STOP;
        end
      end
      ST_WRITE_DATA: begin
        write_data_cnt_o = 1'b1;
        if (wrap && bit_cnt == 3'd7) next_state = ST_READ_ACK;
      end
      ST_READ_DATA: begin
        read_data_cnt_o = 1'b1;
        if (wrap && bit_cnt == 3'd7) next_state = ST_WRITE_ACK;
      end
      ST_WRITE_ACK: begin
        write_ack_cnt_o = 1'b1;
        ack_bit_o       = (bytes_left == 8'd0);
        if (wrap) begin
          if (bytes_left != 8'd0) next_state = ST_READ_DATA;
          else                    next_state = accept ? ST_REPEAT_START : ST_STOP;
        end
      end
      ST_REPEAT_START: begin
        repeat_start_cnt_o = 1'b1;
        hold               = 1'b1;
        force_high         = (rs_cnt <= {1'b0, presc});
        if (rs_cnt == 9'd1) next_state = ST_WRITE_ADDR;
      end
      ST_STOP: begin
        stop_cnt_o = 1'b1;
        if (wrap) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i2c_core_clock_i or posedge reset_bit_i) begin
    if (reset_bit_i) begin
      state      <= ST_IDLE;
      addr_rw_q  <= '0;
      bytes_left <= '0;
      presc      <= '0;
      bit_cnt    <= '0;
      ack_q      <= 1'b0;
      rs_cnt     <= '0;
      nack_err_o <= 1'b0;
      tx_req_o   <= 1'b0;
      rx_valid_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        addr_rw_q  <= addr_rw_i;
        bytes_left <= byte_count_i;
        presc      <= p_eff;
        nack_err_o <= 1'b0;
      end else if ((next_state != state) &&
                   ((next_state == ST_WRITE_DATA) || (next_state == ST_READ_DATA))) begin
        bytes_left <= bytes_left - 8'd1;
      end
      if (byte_state && wrap) bit_cnt <= bit_cnt + 3'd1;
      if ((state == ST_READ_ACK) && rise) begin
        ack_q <= sda_i;
        if (sda_i) nack_err_o <= 1'b1;
      end
      if ((next_state == ST_REPEAT_START) && (state != ST_REPEAT_START)) begin
        rs_cnt <= {p_eff, 1'b0};
      end else if (state == ST_REPEAT_START) begin
        rs_cnt <= rs_cnt - 9'd1;
      end
      // Byte request waits for a good ACK sample so a NACKed slave never sees one.
      tx_req_o   <= (state == ST_READ_ACK) && rise && !sda_i &&
                    (bytes_left != 8'd0) && !addr_rw_q[0];
      rx_valid_o <= (state == ST_READ_DATA) && (next_state == ST_WRITE_ACK);
      done_o     <= (state == ST_STOP) && wrap;
    end
  end

endmodule

// File: tb/tb_i2c_master_fsm_block.sv
// Scoreboarded random/directed bench for the I2C master transaction controller.
module tb_i2c_master_fsm_block;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [7:0] addr_rw_i = '0, byte_count_i = '0, prescaler_i = '0;
  logic       sda_i = 1'b0;
  logic       scl_o;
  logic       start_cnt_o, write_addr_cnt_o, write_data_cnt_o, read_data_cnt_o;
  logic       write_ack_cnt_o, read_ack_cnt_o, stop_cnt_o, repeat_start_cnt_o;
  logic [7:0] counter_detect_edge_o, countdown;
  logic       ack_bit_o, tx_req_o, rx_valid_o, done_o, nack_err_o;
  logic [7:0] strobes;

  i2c_master_fsm_block #(.MIN_PRESCALER(2)) dut (
    .i2c_core_clock_i(clk), .reset_bit_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .addr_rw_i(addr_rw_i), .byte_count_i(byte_count_i), .prescaler_i(prescaler_i),
    .sda_i(sda_i), .scl_o(scl_o),
    .start_cnt_o(start_cnt_o), .write_addr_cnt_o(write_addr_cnt_o),
    .write_data_cnt_o(write_data_cnt_o), .read_data_cnt_o(read_data_cnt_o),
    .write_ack_cnt_o(write_ack_cnt_o), .read_ack_cnt_o(read_ack_cnt_o),
    .stop_cnt_o(stop_cnt_o), .repeat_start_cnt_o(repeat_start_cnt_o),
    .counter_detect_edge_o(counter_detect_edge_o),
    .counter_state_done_time_repeat_start_o(countdown),
    .ack_bit_o(ack_bit_o), .tx_req_o(tx_req_o), .rx_valid_o(rx_valid_o),
    .done_o(done_o), .nack_err_o(nack_err_o)
  );

  assign strobes = {start_cnt_o, write_addr_cnt_o, write_data_cnt_o, read_data_cnt_o,
                    write_ack_cnt_o, read_ack_cnt_o, stop_cnt_o, repeat_start_cnt_o};

  always #5 clk = ~clk;

  typedef struct {
    int lat; int nack; int tx; int rx; int ack_mask; int falls; int rd;
  } exp_t;

  exp_t sb[$];
  int compared = 0, mismatched = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: whole-transaction shape derived from phase counts, not from the FSM.
  function automatic exp_t model(input int presc, input int addr, input int bc, input int nk);
    exp_t e;
    int p, periods;
    p = (presc < 2) ? 2 : presc;
    periods = nk ? 10 : 10 + 9 * bc;
    e.nack     = nk;
    e.lat      = 2 * p * (1 + periods);
    e.falls    = periods;
    e.tx       = (!nk && !(addr & 1)) ? bc : 0;
    e.rx       = (!nk && (addr & 1)) ? bc : 0;
    e.ack_mask = (e.rx > 0) ? (1 << (bc - 1)) : 0;
    e.rd       = e.rx * 16 * p;
    return e;
  endfunction

  // Monitor: gathers per-transaction observations, compares when done_o appears.
  bit in_txn = 1'b0, prev_scl = 1'b1;
  int acc_edge, tx_n, rx_n, ack_m, falls, rd_n, bad_hot;
  always @(negedge clk) begin
    if (rst) begin
      in_txn = 1'b0;
    end else begin
      if (in_txn) begin
        if (done_o) begin
          in_txn = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("latency", cyc - acc_edge, e.lat);
            chk("nack_err", int'(nack_err_o), e.nack);
            chk("tx_req_count", tx_n, e.tx);
            chk("rx_valid_count", rx_n, e.rx);
            chk("ack_bits", ack_m, e.ack_mask);
            chk("scl_falls", falls, e.falls);
            chk("read_data_cycles", rd_n, e.rd);
            chk("onehot_violations", bad_hot, 0);
          end
        end else begin
          if (tx_req_o) tx_n++;
          if (rx_valid_o) begin
            ack_m = ack_m | (int'(ack_bit_o) << rx_n);
            rx_n++;
          end
          if (prev_scl && !scl_o) falls++;
          if (read_data_cnt_o) rd_n++;
          if ($countones(strobes) != 1) bad_hot++;
        end
        prev_scl = scl_o;
      end
      if (!in_txn && mon_en && cmd_valid_i && cmd_ready_o) begin
        in_txn = 1'b1; acc_edge = cyc + 1; prev_scl = 1'b1;
        tx_n = 0; rx_n = 0; ack_m = 0; falls = 0; rd_n = 0; bad_hot = 0;
      end
    end
  end

  task automatic run_txn(input int presc, input int addr, input int bc, input int nk);
    sb.push_back(model(presc, addr, bc, nk));
    mon_en       = 1'b1;
    sda_i        = nk[0];
    prescaler_i  = 8'(presc);
    addr_rw_i    = 8'(addr);
    byte_count_i = 8'(bc);
    cmd_valid_i  = 1'b1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("txn_timeout", 0, 1);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit found;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", int'(scl_o), 1);
    chk("rst_cmd_ready", int'(cmd_ready_o), 1);
    chk("rst_strobes", int'(strobes), 0);
    chk("rst_edge_cnt", int'(counter_detect_edge_o), 0);
    chk("rst_countdown", int'(countdown), 0);
    chk("rst_pulses", int'({done_o, tx_req_o, rx_valid_o, nack_err_o, ack_bit_o}), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_txn(4, 'hA0, 1, 0);   // 160-clock write
    run_txn(4, 'hA0, 1, 1);   // address NACK
    run_txn(4, 'hA1, 2, 0);   // two-byte read
    run_txn(0, 'hA0, 0, 0);   // prescaler floor, probe
    for (int t = 0; t < 12; t++) begin
      int rw;
      rw = int'($urandom_range(0, 1));
      run_txn(int'($urandom_range(0, 6)), (int'($urandom_range(0, 127)) << 1) | rw,
              int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    // Repeated start: second command waits at the final ACK.
    mon_en = 1'b0;
    sda_i = 1'b0; prescaler_i = 8'd4; addr_rw_i = 8'hA0; byte_count_i = 8'd1;
    cmd_valid_i = 1'b1;
    @(posedge clk); #1;
    addr_rw_i = 8'hA1; byte_count_i = 8'd0;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (repeat_start_cnt_o) begin found = 1'b1; break; end
    end
    chk("rs_entered", int'(found), 1);
    cmd_valid_i = 1'b0;
    chk("rs_countdown_load", int'(countdown), 8);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!repeat_start_cnt_o) break;
      if (countdown == 8'd5) chk("rs_scl_low", int'(scl_o), 0);
      if (countdown == 8'd4) chk("rs_scl_high", int'(scl_o), 1);
      n++;
      @(negedge clk);
    end
    chk("rs_cycles", n, 8);
    chk("rs_then_addr", int'(write_addr_cnt_o), 1);
    chk("rs_countdown_end", int'(countdown), 0);
    chk("rs_edge_zero", int'(counter_detect_edge_o), 0);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done_o) begin found = 1'b1; break; end
    end
    chk("rs_done", int'(found), 1);
    chk("rs_nack", int'(nack_err_o), 0);
    @(posedge clk); #1;

    // Reset during a write byte aborts at once.
    sda_i = 1'b0; prescaler_i = 8'd4; addr_rw_i = 8'hA0; byte_count_i = 8'd2;
    cmd_valid_i = 1'b1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (write_data_cnt_o) begin found = 1'b1; break; end
    end
    chk("wd_entered", int'(found), 1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_scl", int'(scl_o), 1);
    chk("abort_strobes", int'(strobes), 0);
    chk("abort_cmd_ready", int'(cmd_ready_o), 1);
    chk("abort_done", int'(done_o), 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_abort_idle_scl", int'(scl_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
